// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point-conversion datapath: default operand
// width, arbiter FSM state encoding, requester ID type and the zero point.
package ecc_pkg;

  localparam int unsigned ECC_WIDTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Requester identifier: 0 = req0, 1 = req1.
  typedef logic req_id_t;

  // Coordinate value of the point at infinity, also used for aborted results.
  localparam logic [ECC_WIDTH-1:0] ZERO_COORD = '0;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick. Purely combinational; the caller owns the
// preference pointer and decides when it advances.
module rr_arb2
  import ecc_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    ptr,
  output logic [1:0] grant,
  output req_id_t    id
);

  // Lone requester wins; with both pending, the preferred one wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    grant = 2'b00;
    id    = ptr;
    case (valid)
      2'b01:   id = 1'b0;
      2'b10:   id = 1'b1;
      default: id = ptr;
    endcase
    if (|valid) grant[id] = 1'b1;
  end

endmodule

// File: rtl/affine_conv_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared Jacobian-to-affine
// converter. Grants one of two requesters, registers its (X3, Y3, Z3) triple,
// starts the converter, and returns the affine result tagged with the owner.
// Z3 = 0 short-circuits to the point at infinity without using the converter.
// Define AFFINE_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with resp_err.
module affine_conv_arbiter
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH          = ECC_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] p,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x3,
  input  logic [WIDTH-1:0] req0_y3,
  input  logic [WIDTH-1:0] req0_z3,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x3,
  input  logic [WIDTH-1:0] req1_y3,
  input  logic [WIDTH-1:0] req1_z3,
  output logic             conv_start,
  output logic [WIDTH-1:0] conv_x3,
  output logic [WIDTH-1:0] conv_y3,
  output logic [WIDTH-1:0] conv_z3,
  output logic [WIDTH-1:0] conv_p,
  input  logic             conv_done,
  input  logic [WIDTH-1:0] conv_x,
  input  logic [WIDTH-1:0] conv_y,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_x,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_inf,
  output logic             resp_err
);

  localparam logic [WIDTH-1:0] ZERO_PT = ZERO_COORD[WIDTH-1:0];

  arb_state_t       state, state_next;
  req_id_t          ptr, ptr_next, pick_id, id_q;
  logic [1:0]       valid_vec, pick_grant, ready_q, accept_vec;
  logic             accept, resp_fire, timeout_hit;
  logic             inf_q, err_q;
  logic [WIDTH-1:0] x3_q, y3_q, z3_q, p_q, x_q, y_q;

  assign valid_vec  = {req1_valid, req0_valid};
  assign accept_vec = ready_q & valid_vec;
  assign accept     = |accept_vec;
  assign resp_fire  = (state == ST_RESP) && resp_ready;

  // The pointer moves off the requester whose response is being accepted; the
  // next grant is computed against that updated preference.
  assign ptr_next = resp_fire ? ~id_q : ptr;

  rr_arb2 u_rr_arb2 (
    .valid (valid_vec),
    .ptr   (ptr_next),
    .grant (pick_grant),
    .id    (pick_id)
  );

`ifdef AFFINE_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Watchdog: counts cycles spent in WAIT, held at zero everywhere else.
  always_ff @(posedge clk) begin
    if (!nrst)                  wait_cnt <= '0;
    else if (state != ST_WAIT)  wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (!nrst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus the two state-derived strobes.
  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (z3_q == ZERO_PT) begin
          state_next = ST_RESP;
        end else begin
          conv_start = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT:  if (conv_done || timeout_hit) state_next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Grant pointer, registered ready pulse, operand latch and result capture.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr     <= 1'b0;
      ready_q <= 2'b00;
      id_q    <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
      z3_q    <= '0;
      p_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      inf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr     <= ptr_next;
      // Ready is registered so no input reaches it combinationally; it is only
      // offered for a cycle in which the FSM will be sitting in IDLE.
      ready_q <= (state_next == ST_IDLE) ? pick_grant : 2'b00;

      if (state == ST_IDLE && accept) begin
        id_q <= accept_vec[1];
        x3_q <= accept_vec[1] ? req1_x3 : req0_x3;
        y3_q <= accept_vec[1] ? req1_y3 : req0_y3;
        z3_q <= accept_vec[1] ? req1_z3 : req0_z3;
        p_q  <= p;
      end

      case (state)
        ST_ISSUE: begin
          if (z3_q == ZERO_PT) begin
            x_q   <= ZERO_PT;
            y_q   <= ZERO_PT;
            inf_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (conv_done) begin
            x_q <= conv_x;
            y_q <= conv_y;
          end else if (timeout_hit) begin
            x_q   <= ZERO_PT;
            y_q   <= ZERO_PT;
            err_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            inf_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign conv_x3    = x3_q;
  assign conv_y3    = y3_q;
  assign conv_z3    = z3_q;
  assign conv_p     = p_q;
  assign resp_id    = id_q;
  assign resp_x     = x_q;
  assign resp_y     = y_q;
  assign resp_inf   = inf_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_affine_conv_arbiter.sv
// Directed bench for affine_conv_arbiter: reset state, single converter
// transaction, infinity bypass with backpressure, round-robin contention,
// reset during WAIT, and (with AFFINE_ARB_TIMEOUT_EN) the watchdog abort.
module tb_affine_conv_arbiter;

  localparam int W = 32;
  localparam logic [W-1:0] P_VAL = 32'hFFFF_FFC5;

  logic         clk = 1'b0;
  logic         nrst;
  logic [W-1:0] p;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_x3, req0_y3, req0_z3, req1_x3, req1_y3, req1_z3;
  logic         conv_start, conv_done;
  logic [W-1:0] conv_x3, conv_y3, conv_z3, conv_p, conv_x, conv_y;
  logic         resp_valid, resp_ready, resp_id, resp_inf, resp_err;
  logic [W-1:0] resp_x, resp_y;

  int errors = 0;
  int checks = 0;

  int         ng, nr, n0, n1, dual;
  logic [3:0] order, rid;

  always #5 clk = ~clk;

  affine_conv_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .p          (p),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x3    (req0_x3),
    .req0_y3    (req0_y3),
    .req0_z3    (req0_z3),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x3    (req1_x3),
    .req1_y3    (req1_y3),
    .req1_z3    (req1_z3),
    .conv_start (conv_start),
    .conv_x3    (conv_x3),
    .conv_y3    (conv_y3),
    .conv_z3    (conv_z3),
    .conv_p     (conv_p),
    .conv_done  (conv_done),
    .conv_x     (conv_x),
    .conv_y     (conv_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_x     (resp_x),
    .resp_y     (resp_y),
    .resp_inf   (resp_inf),
    .resp_err   (resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    nrst = 1'b0; p = P_VAL;
    req0_valid = 1'b0; req0_x3 = '0; req0_y3 = '0; req0_z3 = '0;
    req1_valid = 1'b0; req1_x3 = '0; req1_y3 = '0; req1_z3 = '0;
    conv_done = 1'b0; conv_x = '0; conv_y = '0; resp_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_start", conv_start, 1'b0);
    chk1("rst_valid", resp_valid, 1'b0);
    chk1("rst_id", resp_id, 1'b0);
    chk1("rst_inf", resp_inf, 1'b0);
    chk1("rst_err", resp_err, 1'b0);
    chkw("rst_x3", conv_x3, 32'h0);
    chkw("rst_p", conv_p, 32'h0);
    chkw("rst_rx", resp_x, 32'h0);

    // Single request through the converter, done 20 cycles after start
    req0_x3 = 32'h5; req0_y3 = 32'h7; req0_z3 = 32'h1; req0_valid = 1'b1;
    nrst = 1'b1;
    tick();
    chk1("single_ready0", req0_ready, 1'b1);
    chk1("single_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    chk1("single_start", conv_start, 1'b1);
    chk1("single_ready_off", req0_ready, 1'b0);
    chkw("single_x3", conv_x3, 32'h5);
    chkw("single_y3", conv_y3, 32'h7);
    chkw("single_z3", conv_z3, 32'h1);
    chkw("single_p", conv_p, P_VAL);
    tick();
    chk1("single_start_once", conv_start, 1'b0);
    chk1("single_wait_valid", resp_valid, 1'b0);
    repeat (19) tick();
    conv_done = 1'b1; conv_x = 32'h5; conv_y = 32'h7;
    chk1("single_no_early", resp_valid, 1'b0);
    tick();
    conv_done = 1'b0; conv_x = '0; conv_y = '0;
    chk1("single_resp_valid", resp_valid, 1'b1);
    chk1("single_resp_id", resp_id, 1'b0);
    chkw("single_resp_x", resp_x, 32'h5);
    chkw("single_resp_y", resp_y, 32'h7);
    chk1("single_resp_inf", resp_inf, 1'b0);
    chk1("single_resp_err", resp_err, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("single_resp_done", resp_valid, 1'b0);

    // Infinity bypass from req1, then 10 cycles of backpressure
    req1_x3 = 32'h9; req1_y3 = 32'h3; req1_z3 = 32'h0; req1_valid = 1'b1;
    tick();
    chk1("inf_ready1", req1_ready, 1'b1);
    chk1("inf_ready0", req0_ready, 1'b0);
    tick();
    req1_valid = 1'b0;
    chk1("inf_no_start", conv_start, 1'b0);
    tick();
    chk1("inf_valid", resp_valid, 1'b1);
    chk1("inf_flag", resp_inf, 1'b1);
    chk1("inf_id", resp_id, 1'b1);
    chkw("inf_x", resp_x, 32'h0);
    chkw("inf_y", resp_y, 32'h0);
    req0_valid = 1'b1; req0_x3 = 32'h55; req0_z3 = 32'h2;
    conv_x = 32'hDEAD; conv_y = 32'hBEEF;
    for (int i = 0; i < 10; i++) begin
      conv_done = (i == 4);
      tick();
      chk1("bp_valid", resp_valid, 1'b1);
      chk1("bp_id", resp_id, 1'b1);
      chk1("bp_inf", resp_inf, 1'b1);
      chk1("bp_ready0", req0_ready, 1'b0);
      chk1("bp_start", conv_start, 1'b0);
      chkw("bp_x", resp_x, 32'h0);
      chkw("bp_y", resp_y, 32'h0);
    end
    conv_done = 1'b0; conv_x = '0; conv_y = '0;
    req0_valid = 1'b0; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("bp_resp_done", resp_valid, 1'b0);
    chk1("bp_inf_clear", resp_inf, 1'b0);
    chk1("bp_no_ready0", req0_ready, 1'b0);

    // Contention from reset: both requesters always valid, bypass path
    nrst = 1'b0;
    req0_x3 = 32'h100; req0_y3 = 32'h101; req0_z3 = 32'h0; req0_valid = 1'b1;
    req1_x3 = 32'h200; req1_y3 = 32'h201; req1_z3 = 32'h0; req1_valid = 1'b1;
    resp_ready = 1'b1;
    tick();
    nrst = 1'b1;
    chk1("cont_rst_ready0", req0_ready, 1'b0);
    ng = 0; nr = 0; n0 = 0; n1 = 0; dual = 0; order = '0; rid = '0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      tick();
      if (ng == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (req0_ready && req1_ready) dual++;
      if (req0_ready || req1_ready) begin
        if (ng < 4) order[ng] = req1_ready;
        ng++;
        if (req0_ready) n0++;
        if (req1_ready) n1++;
      end
      if (resp_valid) begin
        if (nr < 4) rid[nr] = resp_id;
        nr++;
      end
    end
    tick();
    resp_ready = 1'b0;
    chkw("cont_resp_count", 32'(nr), 32'h4);
    chkw("cont_grant_count", 32'(ng), 32'h4);
    chkw("cont_ready0_pulses", 32'(n0), 32'h2);
    chkw("cont_ready1_pulses", 32'(n1), 32'h2);
    chkw("cont_dual_ready", 32'(dual), 32'h0);
    chk1("cont_order0", order[0], 1'b0);
    chk1("cont_order1", order[1], 1'b1);
    chk1("cont_order2", order[2], 1'b0);
    chk1("cont_order3", order[3], 1'b1);
    chk1("cont_rid0", rid[0], 1'b0);
    chk1("cont_rid1", rid[1], 1'b1);
    chk1("cont_rid2", rid[2], 1'b0);
    chk1("cont_rid3", rid[3], 1'b1);
    chk1("cont_drained", resp_valid, 1'b0);

    // Reset while in WAIT, then a fresh req0 served normally
    req0_x3 = 32'h11; req0_y3 = 32'h22; req0_z3 = 32'h4; req0_valid = 1'b1;
    tick();
    chk1("rw_ready0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    chk1("rw_start", conv_start, 1'b1);
    tick(); tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk1("rw_ready0_zero", req0_ready, 1'b0);
    chk1("rw_ready1_zero", req1_ready, 1'b0);
    chk1("rw_start_zero", conv_start, 1'b0);
    chk1("rw_valid_zero", resp_valid, 1'b0);
    chk1("rw_id_zero", resp_id, 1'b0);
    chk1("rw_inf_zero", resp_inf, 1'b0);
    chk1("rw_err_zero", resp_err, 1'b0);
    chkw("rw_x3_zero", conv_x3, 32'h0);
    chkw("rw_y3_zero", conv_y3, 32'h0);
    chkw("rw_z3_zero", conv_z3, 32'h0);
    chkw("rw_p_zero", conv_p, 32'h0);
    chkw("rw_rx_zero", resp_x, 32'h0);
    chkw("rw_ry_zero", resp_y, 32'h0);
    req0_x3 = 32'h31; req0_y3 = 32'h32; req0_z3 = 32'h33; req0_valid = 1'b1;
    tick();
    chk1("rw2_ready0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    chk1("rw2_start", conv_start, 1'b1);
    chkw("rw2_z3", conv_z3, 32'h33);
    tick(); tick();
    conv_done = 1'b1; conv_x = 32'hAA; conv_y = 32'hBB;
    tick();
    conv_done = 1'b0; conv_x = '0; conv_y = '0;
    chk1("rw2_valid", resp_valid, 1'b1);
    chk1("rw2_id", resp_id, 1'b0);
    chkw("rw2_x", resp_x, 32'hAA);
    chkw("rw2_y", resp_y, 32'hBB);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("rw2_done", resp_valid, 1'b0);

`ifdef AFFINE_ARB_TIMEOUT_EN
    // Watchdog: converter never answers, abort lands at start+17
    req0_x3 = 32'h44; req0_y3 = 32'h45; req0_z3 = 32'h1; req0_valid = 1'b1;
    tick(); tick();
    req0_valid = 1'b0;
    chk1("to_start", conv_start, 1'b1);
    repeat (16) tick();
    chk1("to_not_yet", resp_valid, 1'b0);
    tick();
    chk1("to_valid", resp_valid, 1'b1);
    chk1("to_err", resp_err, 1'b1);
    chkw("to_x", resp_x, 32'h0);
    chkw("to_y", resp_y, 32'h0);
    conv_done = 1'b1; conv_x = 32'h77; conv_y = 32'h88;
    tick();
    conv_done = 1'b0; conv_x = '0; conv_y = '0;
    chk1("to_late_err", resp_err, 1'b1);
    chkw("to_late_x", resp_x, 32'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("to_err_clear", resp_err, 1'b0);
    chk1("to_done", resp_valid, 1'b0);
`else
    // Without the watchdog a silent converter keeps WAIT indefinitely
    req0_x3 = 32'h44; req0_y3 = 32'h45; req0_z3 = 32'h1; req0_valid = 1'b1;
    tick(); tick();
    req0_valid = 1'b0;
    chk1("nt_start", conv_start, 1'b1);
    repeat (40) tick();
    chk1("nt_still_waiting", resp_valid, 1'b0);
    chk1("nt_err_tied", resp_err, 1'b0);
    conv_done = 1'b1; conv_x = 32'h66; conv_y = 32'h67;
    tick();
    conv_done = 1'b0;
    chk1("nt_valid", resp_valid, 1'b1);
    chkw("nt_x", resp_x, 32'h66);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/affine_conv_arbiter.md
# affine_conv_arbiter

Two-requester round-robin arbiter and sequencer for the shared Jacobian-to-affine converter. It accepts (X3, Y3, Z3) triples from two point-arithmetic cores and registers the winning triple. It then pulses the converter start, waits for the converter's done pulse, and returns the affine (x, y) with the requester ID. Z3 = 0 (point at infinity) bypasses the converter entirely.

## Interface
Parameters:
- WIDTH, 256, operand and modulus width
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with the macro)

Ports:
- clk  in  1  clock; all logic on the rising edge
- nrst  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- p  in  WIDTH  field modulus, quasi-static, forwarded to conv_p
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  one-cycle accept pulse
- req0_x3/y3/z3, req1_x3/y3/z3  in  WIDTH each  Jacobian operands, sampled on accept
- conv_start  out  1  one-cycle start pulse to the converter's flag_input
- conv_x3, conv_y3, conv_z3, conv_p  out  WIDTH  registered operands, stable from ISSUE through WAIT
- conv_done  in  1  converter flag_output pulse
- conv_x, conv_y  in  WIDTH  converter results, valid in the conv_done cycle
- resp_valid  out  1  response held until resp_ready
- resp_ready  in  1  consumer accept
- resp_id  out  1  requester that owns the response
- resp_x, resp_y  out  WIDTH  affine result
- resp_inf  out  1  result is the point at infinity (x = y = 0)
- resp_err  out  1  watchdog abort; constant 0 without the macro

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester, pulse its reqN_ready, latch its triple and the grant ID, then go to ISSUE.
  - Only one requester is granted per cycle.
- Arbitration:
  - One pending requester: it wins.
  - Both pending: the requester not granted last wins.
  - The pointer resets to "req0 preferred" and updates when a response is accepted.
- ISSUE:
  - Latched z3 == 0: set resp_inf = 1, x = y = 0, skip the converter, go to RESP.
  - Otherwise: assert conv_start for this one cycle, go to WAIT.
- WAIT: on conv_done, latch conv_x/conv_y into resp_x/resp_y and go to RESP.
- RESP:
  - resp_valid = 1, with resp_id, resp_x, resp_y, resp_inf and resp_err held stable.
  - On resp_valid && resp_ready, go to IDLE and clear the flags.
- conv_done in any state other than WAIT is ignored.
- Requests are never queued. reqN_ready stays low outside IDLE.
- Back-to-back grants to the same requester are legal if the other requester is idle.
- Reset values: all outputs 0, state IDLE, pointer req0, operand and result registers 0.
- Reset asserted mid-operation discards the transaction. The converter shares nrst.

## Timing
- Accept at cycle t (reqN_ready = 1).
- conv_start at t+1.
- WAIT entered at t+2.
- conv_done at cycle d gives resp_valid at d+1.
- Infinity bypass: resp_valid at t+2.
- With resp_ready tied high, the next accept is possible 1 cycle after the resp_valid cycle. Minimum period for the bypass path is 3 cycles.
- No combinational path from any input to reqN_ready, conv_start or resp_valid.

## Configuration
- AFFINE_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT and clears on entry.
  - When it reaches TIMEOUT_CYCLES without conv_done, go to RESP with resp_err = 1 and x = y = 0.
  - A late conv_done after the abort is ignored.
- AFFINE_ARB_TIMEOUT_EN undefined: no counter exists, WAIT waits indefinitely, resp_err is tied 0.

## Structure
- Shared package ecc_pkg holds:
  - the WIDTH default
  - the FSM state enum
  - the requester-ID type
  - the zero-point constant
- Sub-module rr_arb2: two-input round-robin pick.
  - Inputs: valids, last-grant pointer.
  - Outputs: one-hot grant, ID.
  - Combinational. The pointer register stays in the parent.

## Test plan
- Single request: req0 with z3 = 1, x3 = 5, y3 = 7, converter model done after 20 cycles -> resp_id = 0, x = 5, y = 7, resp_valid exactly 21 cycles after conv_start.
- Contention: both valid from reset -> grant order 0, 1, 0, 1 over four transactions; each reqN_ready pulses once per grant.
- Infinity: req1 with z3 = 0 -> conv_start never asserts; resp_valid at accept+2 with resp_inf = 1, x = y = 0, resp_id = 1.
- Backpressure: hold resp_ready = 0 for 10 cycles -> resp fields stable, no reqN_ready, a stray conv_done ignored.
- Reset mid-WAIT: drop nrst for 1 cycle -> next cycle all outputs 0 and state IDLE; a subsequent req0 is served normally.
- With AFFINE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, converter never done -> resp_err = 1 at start+17, then a late conv_done is ignored.
